// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: cache geometry macros, FSM state encodings and state type for dcache_ctrl (DCACHE_STATS_EN enables statistics)
`ifndef DBLOCK_SIZE
`define DBLOCK_SIZE 16
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif
`ifndef DBLOCK_OFFSET_SIZE
`define DBLOCK_OFFSET_SIZE 4
`endif
`ifndef DSET_INDEX_SIZE
`define DSET_INDEX_SIZE 6
`endif
`ifndef DTAG_SIZE
`define DTAG_SIZE 22
`endif
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 28
`endif
`define DC_S_IDLE 3'd0
`define DC_S_LOOKUP 3'd1
`define DC_S_WRITEBACK 3'd2
`define DC_S_REFILL 3'd3
`define DC_S_FILL 3'd4

package dcache_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = `DC_S_IDLE,
    LOOKUP    = `DC_S_LOOKUP,
    WRITEBACK = `DC_S_WRITEBACK,
    REFILL    = `DC_S_REFILL,
    FILL      = `DC_S_FILL
  } state_t;
  localparam int WORDS = `DBLOCK_SIZE / 4;
endpackage

// File: rtl/dcache_stats.sv
// dcache_stats: saturating 32-bit hit/miss/writeback event counters
module dcache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_i,
  input  logic        miss_i,
  input  logic        wb_i,
  output logic [31:0] hits_o,
  output logic [31:0] misses_o,
  output logic [31:0] wbs_o
);
  logic [31:0] hits_q, misses_q, wbs_q;
  // count each event, holding at all-ones once saturated
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      hits_q   <= hits_q + {31'b0, hit_i & ~&hits_q};
      misses_q <= misses_q + {31'b0, miss_i & ~&misses_q};
      wbs_q    <= wbs_q + {31'b0, wb_i & ~&wbs_q};
    end
  assign hits_o   = hits_q;
  assign misses_o = misses_q;
  assign wbs_o    = wbs_q;
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: blocking write-back data cache controller FSM (DCACHE_STATS_EN adds stat_* counters)
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cpu_req,
  input  logic                               cpu_we,
  input  logic [31:0]                        cpu_addr,
  input  logic [3:0]                         cpu_be,
  input  logic [31:0]                        cpu_wdata,
  output logic                               cpu_ready,
  output logic [31:0]                        cpu_rdata,
  output logic                               sram_ren,
  output logic                               sram_wen,
  output logic                               sram_memwen,
  output logic [`DBLOCK_SIZE-1:0]            sram_bytes,
  output logic [`DMEM_BLOCK_ADDR_SIZE-1:0]   sram_blockaddr,
  output logic [`DBLOCK_SIZE_BITS-1:0]       sram_din,
  input  logic                               sram_hit,
  input  logic                               sram_dirty,
  input  logic [`DBLOCK_SIZE_BITS-1:0]       sram_dout,
  input  logic [`DTAG_SIZE-1:0]              sram_victim_tag,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [`DMEM_BLOCK_ADDR_SIZE-1:0]   mem_addr,
  output logic [`DBLOCK_SIZE_BITS-1:0]       mem_wdata,
  input  logic [`DBLOCK_SIZE_BITS-1:0]       mem_rdata,
  input  logic                               mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                        stat_hits,
  output logic [31:0]                        stat_misses,
  output logic [31:0]                        stat_writebacks
`endif
);
  state_t                             state_q;
  logic                               we_q;
  logic [31:2]                        addr_q;
  logic [3:0]                         be_q;
  logic [31:0]                        wdata_q;
  logic [`DBLOCK_SIZE_BITS-1:0]       buf_q;
  logic [`DMEM_BLOCK_ADDR_SIZE-1:0]   victim_q;
  logic [`DMEM_BLOCK_ADDR_SIZE-1:0]   blk;
  logic [`DBLOCK_OFFSET_SIZE-3:0]     woff;
  logic                               lk, wb, rf, fl;
  assign blk  = addr_q[`DBLOCK_OFFSET_SIZE +: `DMEM_BLOCK_ADDR_SIZE];
  assign woff = addr_q[`DBLOCK_OFFSET_SIZE-1:2];
  assign lk   = state_q == LOOKUP;
  assign wb   = state_q == WRITEBACK;
  assign rf   = state_q == REFILL;
  assign fl   = state_q == FILL;
  // main FSM; one block buffer serves writeback data first, then refill data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      victim_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr[31:2];
          be_q    <= cpu_be;
          wdata_q <= cpu_wdata;
          state_q <= LOOKUP;
        end
        LOOKUP: if (sram_hit) state_q <= IDLE;
          else if (sram_dirty) begin
            buf_q    <= sram_dout;
            victim_q <= {sram_victim_tag, blk[`DSET_INDEX_SIZE-1:0]};
            state_q  <= WRITEBACK;
          end else state_q <= REFILL;
        WRITEBACK: if (mem_ack) state_q <= REFILL;
        REFILL: if (mem_ack) begin
          buf_q   <= mem_rdata;
          state_q <= FILL;
        end
        FILL: state_q <= LOOKUP;
        default: state_q <= IDLE;
      endcase
    end
  // outputs decoded from state and the latched request
  always_comb begin
    sram_ren       = lk & ~we_q;
    sram_wen       = lk & we_q;
    sram_memwen    = fl;
    sram_bytes     = sram_wen ? {{(`DBLOCK_SIZE-4){1'b0}}, be_q} << {woff, 2'b00} : '0;
    sram_blockaddr = state_q == IDLE ? '0 : blk;
    sram_din       = fl ? buf_q : sram_wen ? {WORDS{wdata_q}} : '0;
    cpu_ready      = lk & sram_hit;
    cpu_rdata      = cpu_ready & ~we_q ? sram_dout[{woff, 5'b0} +: 32] : '0;
    mem_req        = wb | rf;
    mem_we         = wb;
    mem_addr       = wb ? victim_q : rf ? blk : '0;
    mem_wdata      = wb ? buf_q : '0;
  end
`ifdef DCACHE_STATS_EN
  logic retry_q;
  // marks the LOOKUP that follows a FILL so its hit is not counted
  always_ff @(posedge clk or negedge rst)
    if (!rst) retry_q <= 1'b0;
    else if (fl) retry_q <= 1'b1;
    else if (state_q == IDLE) retry_q <= 1'b0;
  dcache_stats u_stats (
    .clk      (clk),
    .rst      (rst),
    .hit_i    (lk & sram_hit & ~retry_q),
    .miss_i   (lk & ~sram_hit),
    .wb_i     (wb & mem_ack),
    .hits_o   (stat_hits),
    .misses_o (stat_misses),
    .wbs_o    (stat_writebacks)
  );
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl with 16-byte blocks
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_be;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         sram_ren, sram_wen, sram_memwen;
  logic [15:0]  sram_bytes;
  logic [27:0]  sram_blockaddr;
  logic [127:0] sram_din;
  logic         sram_hit, sram_dirty;
  logic [127:0] sram_dout;
  logic [21:0]  sram_victim_tag;
  logic         mem_req, mem_we;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  stat_hits, stat_misses, stat_writebacks;
`endif
  int checks = 0;
  int failures = 0;
  localparam logic [127:0] BLK_A  = 128'h44444444_33333333_11112222_00000001;
  localparam logic [127:0] BLK_R  = 128'hDEAD0003_BEEF0002_CAFE0001_F00D0000;
  localparam logic [127:0] BLK_R2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] BLK_V  = 128'h55555555_AAAAAAAA_5A5A5A5A_A5A5A5A5;

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_memwen(sram_memwen),
    .sram_bytes(sram_bytes), .sram_blockaddr(sram_blockaddr), .sram_din(sram_din),
    .sram_hit(sram_hit), .sram_dirty(sram_dirty), .sram_dout(sram_dout),
    .sram_victim_tag(sram_victim_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_be = 0; cpu_wdata = 0;
    sram_hit = 0; sram_dirty = 0; sram_dout = 0; sram_victim_tag = 0;
    mem_rdata = 0; mem_ack = 0;
    repeat (2) cyc;
    #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_blkaddr", sram_blockaddr, 0);
    chk("rst_sram", {sram_ren, sram_wen, sram_memwen}, 0);
    cyc; rst = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104; #1;
    chk("acc_ready", cpu_ready, 0);
    cyc; cpu_req = 0; cpu_addr = 0; sram_hit = 1; sram_dout = BLK_A; #1;
    chk("ld_ready", cpu_ready, 1);
    chk("ld_sram", {sram_ren, sram_wen, sram_memwen}, 3'b100);
    chk("ld_blkaddr", sram_blockaddr, 28'h10);
    chk("ld_rdata", cpu_rdata, 32'h11112222);
    cyc; sram_hit = 0; #1;
    chk("ld_idle_ready", cpu_ready, 0);
    chk("ld_idle_rdata", cpu_rdata, 0);
    chk("ld_idle_blkaddr", sram_blockaddr, 0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10A; cpu_be = 4'b1100; cpu_wdata = 32'hAABBCCDD;
    cyc; cpu_req = 0; cpu_wdata = 0; cpu_be = 0; sram_hit = 1; #1;
    chk("st_sram", {sram_ren, sram_wen, sram_memwen}, 3'b010);
    chk("st_bytes", sram_bytes, 16'h0C00);
    chk("st_din", sram_din, {4{32'hAABBCCDD}});
    chk("st_ready", cpu_ready, 1);
    chk("st_rdata", cpu_rdata, 0);
    cyc; sram_hit = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h106; cpu_be = 4'b1100; cpu_wdata = 32'h01020304;
    cyc; cpu_req = 0; sram_hit = 1; #1;
    chk("st2_bytes", sram_bytes, 16'h00C0);
    chk("st2_ready", cpu_ready, 1);
    cyc; sram_hit = 0; cpu_we = 0;
    mem_ack = 1; #1;
    chk("idle_ack_req", mem_req, 0);
    cyc; mem_ack = 0; #1;
    chk("idle_ack_sram", {sram_ren, sram_wen, sram_memwen, mem_req}, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    cyc; cpu_req = 0; #1;
    chk("cm_lk_sram", {sram_ren, sram_wen, sram_memwen}, 3'b100);
    chk("cm_lk_ready", cpu_ready, 0);
    chk("cm_lk_memreq", mem_req, 0);
    cyc; #1;
    chk("cm_rf_req", {mem_req, mem_we}, 2'b10);
    chk("cm_rf_addr", mem_addr, 28'h10);
    chk("cm_rf_sram", {sram_ren, sram_wen, sram_memwen}, 0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h500;
    repeat (4) cyc;
    cpu_req = 0; cpu_we = 0; #1;
    chk("cm_hold", {mem_req, mem_we, mem_addr}, {2'b10, 28'h10});
    cyc; mem_ack = 1; mem_rdata = BLK_R;
    cyc; mem_ack = 0; mem_rdata = 0; #1;
    chk("cm_fill_sram", {sram_ren, sram_wen, sram_memwen}, 3'b001);
    chk("cm_fill_din", sram_din, BLK_R);
    chk("cm_fill_memreq", mem_req, 0);
    cyc; sram_hit = 1; sram_dout = BLK_R; #1;
    chk("cm_ready", cpu_ready, 1);
    chk("cm_rdata", cpu_rdata, 32'hF00D0000);
    chk("cm_retry_sram", {sram_ren, sram_wen, sram_memwen}, 3'b100);
    cyc; sram_hit = 0; sram_dout = 0;
    cpu_req = 1; cpu_addr = 32'h234;
    cyc; cpu_req = 0; sram_dirty = 1; sram_victim_tag = 22'h3; sram_dout = BLK_V; #1;
    chk("dm_lk_ready", cpu_ready, 0);
    cyc; sram_dirty = 0; sram_victim_tag = 0; sram_dout = 0; #1;
    chk("dm_wb_req", {mem_req, mem_we}, 2'b11);
    chk("dm_wb_addr", mem_addr, 28'hE3);
    chk("dm_wb_data", mem_wdata, BLK_V);
    repeat (2) cyc;
    #1;
    chk("dm_wb_hold", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 28'hE3, BLK_V});
    mem_ack = 1;
    cyc; mem_ack = 0; #1;
    chk("dm_rf_req", {mem_req, mem_we}, 2'b10);
    chk("dm_rf_addr", mem_addr, 28'h23);
    chk("dm_rf_wdata", mem_wdata, 0);
    mem_ack = 1; mem_rdata = BLK_R2;
    cyc; mem_ack = 0; mem_rdata = 0; #1;
    chk("dm_fill_sram", {sram_ren, sram_wen, sram_memwen, mem_req}, 4'b0010);
    chk("dm_fill_din", sram_din, BLK_R2);
    cyc; sram_hit = 1; sram_dout = BLK_R2; #1;
    chk("dm_ready", cpu_ready, 1);
    chk("dm_rdata", cpu_rdata, 32'hFEDCBA98);
`ifdef DCACHE_STATS_EN
    chk("stat_hits", stat_hits, 3);
    chk("stat_misses", stat_misses, 2);
    chk("stat_writebacks", stat_writebacks, 1);
`endif
    cyc; sram_hit = 0; sram_dout = 0;
    cpu_req = 1; cpu_addr = 32'h100;
    cyc; cpu_req = 0;
    cyc; #1;
    chk("rr_req", mem_req, 1);
    cyc; rst = 0; #1;
    chk("rr_req_drop", mem_req, 0);
    chk("rr_blkaddr", sram_blockaddr, 0);
    mem_ack = 1; mem_rdata = BLK_R;
    cyc; mem_ack = 0; mem_rdata = 0; #1;
    chk("rr_no_fill", {sram_ren, sram_wen, sram_memwen, mem_req}, 0);
    rst = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104; #1;
    chk("rr_idle_req", mem_req, 0);
    cyc; cpu_req = 0; sram_hit = 1; sram_dout = BLK_A; #1;
    chk("post_ready", cpu_ready, 1);
    chk("post_rdata", cpu_rdata, 32'h11112222);
`ifdef DCACHE_STATS_EN
    chk("post_stat_misses", stat_misses, 0);
`endif
    cyc; sram_hit = 0;
    cyc;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
